receiver: RTL and testbench
===========================

RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL provide parameter DATA_W, default 10, number of data bits per frame.
REQ-002 SHALL provide port i_clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL provide port i_rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL provide port i_seq_bit, input, 1, serial data bit, MSB first.
REQ-005 SHALL provide port i_bit_valid, input, 1, i_seq_bit qualifier; one bit per high cycle.
REQ-006 SHALL provide port i_tx_done, input, 1, single-cycle end-of-frame strobe from the transmitter.
REQ-007 SHALL provide port o_data, output, DATA_W, last good received word; held until the next good frame.
REQ-008 SHALL provide port o_data_valid, output, 1, one-cycle pulse when o_data updates.
REQ-009 SHALL provide port o_frame_err, output, 1, one-cycle pulse on bad bit count.
REQ-010 SHALL provide port o_busy, output, 1, high while a frame is being collected (state SHIFT or CHECK).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and CHECK.
REQ-012 SHALL keep a shift register sr[DATA_W-1:0]; each accepted bit loads sr <= {sr[DATA_W-2:0], i_seq_bit}.
REQ-013 SHALL keep a bit counter bcnt, width clog2(DATA_W+2), saturating at DATA_W+1; any bit beyond DATA_W sets an overrun flag.
REQ-014 In IDLE, i_bit_valid=1 SHALL accept the bit, set bcnt=1, clear overrun and go to SHIFT.
REQ-015 In IDLE, i_tx_done SHALL be ignored, with no pulse on any output.
REQ-016 In SHIFT, each i_bit_valid=1 cycle SHALL accept one bit; with i_bit_valid=0, sr and bcnt hold.
REQ-017 In SHIFT, i_tx_done=1 SHALL go to CHECK; a bit valid in the same cycle is accepted first and counts toward the frame.
REQ-018 CHECK SHALL last exactly one cycle and then go to IDLE.
REQ-019 In CHECK, if bcnt==DATA_W and overrun=0, the block SHALL load o_data <= sr and pulse o_data_valid.
REQ-020 In CHECK, if bcnt!=DATA_W or overrun=1, the block SHALL pulse o_frame_err and leave o_data unchanged.
REQ-021 Latency: the valid or error pulse SHALL be high during the cycle after CHECK, i.e. two rising edges after the edge that samples i_tx_done.
REQ-022 In CHECK, i_bit_valid=1 SHALL be taken as bit 1 of the next frame (bcnt=1, state SHIFT), with no bit lost.
REQ-023 In CHECK, i_tx_done=1 SHALL be ignored.
REQ-024 o_data_valid and o_frame_err SHALL never be high in the same cycle.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 When i_rst=1 at a rising edge, the block SHALL set state=IDLE, sr=0, bcnt=0, overrun=0, o_data=0, o_data_valid=0, o_frame_err=0 and o_busy=0.
REQ-027 Reset mid-frame SHALL discard the partial frame with no pulse; reset has priority over every input.

Structure
REQ-028 FSM state encodings and the DATA_W default SHALL live in the shared project package, used by both transmiter and receiver.
REQ-029 The block SHALL be a single module; no sub-module is required.

Verification
REQ-030 Reset then frame 10'd15 (bits 0000001111, one per cycle) with i_tx_done on the tenth bit cycle -> o_data=10'h00F, one o_data_valid pulse two edges later.
REQ-031 Frame 10'h2AA sent with gaps of 0-3 idle cycles between valid bits, i_tx_done after the last bit -> o_data=10'h2AA, no o_frame_err.
REQ-032 Nine bits then i_tx_done -> o_frame_err pulse; o_data keeps the previous value 10'h2AA.
REQ-033 Twelve bits then i_tx_done -> o_frame_err pulse, because bcnt saturates and overrun is set.
REQ-034 Back-to-back frames 10'h3FF then 10'h001, with the next frame's first bit in the CHECK cycle -> two o_data_valid pulses, values 10'h3FF then 10'h001.
REQ-035 i_rst pulsed after five bits, then a full frame 10'h155 -> no pulse from the aborted frame, then o_data=10'h155.

Source files
------------

// File: rtl/receiver_pkg.sv
// -----------------------------------------------------------------------------
// receiver_pkg
// Shared project definitions for the serial link (transmitter and receiver):
//   - DATA_W_DEFAULT : default number of data bits per frame
//   - state_e        : frame FSM state encoding (IDLE / SHIFT / CHECK)
// No ports; this file only holds types and constants.
// -----------------------------------------------------------------------------
package receiver_pkg;

  localparam int unsigned DATA_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

endpackage : receiver_pkg

// File: rtl/receiver.sv
// -----------------------------------------------------------------------------
// receiver
// Collects an MSB-first serial frame, checks its bit count when the
// transmitter signals end of frame, and publishes good words.
//
// Ports:
//   i_clk         in   1       sole clock, rising edge
//   i_rst         in   1       synchronous active-high reset
//   i_seq_bit     in   1       serial data bit, MSB first
//   i_bit_valid   in   1       qualifies i_seq_bit, one bit per high cycle
//   i_tx_done     in   1       single-cycle end-of-frame strobe
//   o_data        out  DATA_W  last good word, held until the next good frame
//   o_data_valid  out  1       one-cycle pulse when o_data updates
//   o_frame_err   out  1       one-cycle pulse on a bad bit count
//   o_busy        out  1       high while in SHIFT or CHECK
// -----------------------------------------------------------------------------
module receiver
  import receiver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_seq_bit,
  input  logic              i_bit_valid,
  input  logic              i_tx_done,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  output logic              o_frame_err,
  output logic              o_busy
);

  // Counter must represent DATA_W+1 (its saturation value).
  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]    bcnt_q, bcnt_d;
  logic                ovr_q, ovr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                dv_q, dv_d;
  logic                fe_q, fe_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   sr_shifted;

  assign sr_shifted = {sr_q[DATA_W-2:0], i_seq_bit};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    ovr_d   = ovr_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // An end-of-frame strobe with no frame in progress is meaningless.
        if (i_bit_valid) begin
          sr_d    = sr_shifted;
          bcnt_d  = CNT_ONE;
          ovr_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (i_bit_valid) begin
          sr_d = sr_shifted;
          // A bit arriving once DATA_W bits are already held is an overrun.
          if (bcnt_q >= CNT_FULL) ovr_d = 1'b1;
          if (bcnt_q != CNT_SAT)  bcnt_d = bcnt_q + CNT_ONE;
        end
        // Same-cycle bit was accepted above, so it counts toward this frame.
        if (i_tx_done) state_d = ST_CHECK;
      end

      ST_CHECK: begin
        // Judge on the registered count/overrun, which exclude any bit
        // arriving now (that bit belongs to the next frame).
        if (bcnt_q == CNT_FULL && !ovr_q) begin
          data_d = sr_q;
          dv_d   = 1'b1;
        end else begin
          fe_d   = 1'b1;
        end
        if (i_bit_valid) begin
          sr_d    = sr_shifted;
          bcnt_d  = CNT_ONE;
          ovr_d   = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      bcnt_q  <= '0;
      ovr_q   <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      ovr_q   <= ovr_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = dv_q;
  assign o_frame_err  = fe_q;
  assign o_busy       = busy_q;

endmodule : receiver

// File: tb/tb_receiver.sv
// -----------------------------------------------------------------------------
// tb_receiver
// Directed-vector bench for receiver with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_receiver;

  localparam int DATA_W = 10;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_seq_bit = 1'b0;
  logic              i_bit_valid = 1'b0;
  logic              i_tx_done = 1'b0;
  logic [DATA_W-1:0] o_data;
  logic              o_data_valid;
  logic              o_frame_err;
  logic              o_busy;

  int tests_run = 0;
  int tests_failed = 0;

  int dv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int dv_base;
  int fe_base;

  receiver #(.DATA_W(DATA_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_seq_bit    (i_seq_bit),
    .i_bit_valid  (i_bit_valid),
    .i_tx_done    (i_tx_done),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (o_data_valid) dv_cnt++;
    if (o_frame_err)  fe_cnt++;
    if (o_data_valid && o_frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Drive one cycle of inputs, advance one rising edge, settle 1 time unit.
  task automatic step(input logic v, input logic b, input logic d);
    i_bit_valid = v;
    i_seq_bit   = b;
    i_tx_done   = d;
    @(posedge i_clk);
    #1;
    i_bit_valid = 1'b0;
    i_seq_bit   = 1'b0;
    i_tx_done   = 1'b0;
  endtask

  // Send bits n-1..0 of val MSB first; optional idle gaps of 0-3 cycles;
  // optionally raise i_tx_done together with the last bit.
  task automatic send_bits(input logic [15:0] val, input int n, input bit gaps, input bit done_last);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) repeat (i % 4) step(1'b0, 1'b0, 1'b0);
      step(1'b1, val[i], done_last && (i == 0));
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    i_rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    check("rst_data",  32'(o_data), 32'h0);
    check("rst_dv",    32'(o_data_valid), 32'h0);
    check("rst_fe",    32'(o_frame_err), 32'h0);
    check("rst_busy",  32'(o_busy), 32'h0);

    // ---------------- tx_done in IDLE is ignored ----------------
    dv_base = dv_cnt; fe_base = fe_cnt;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("idle_done_dv",   32'(dv_cnt - dv_base), 32'h0);
    check("idle_done_fe",   32'(fe_cnt - fe_base), 32'h0);
    check("idle_done_busy", 32'(o_busy), 32'h0);

    // ---------------- frame 10'h00F, done with tenth bit ----------------
    send_bits(16'h000F, 10, 1'b0, 1'b1);
    check("f00f_no_early_dv", 32'(o_data_valid), 32'h0);
    check("f00f_busy_check",  32'(o_busy), 32'h1);
    step(1'b0, 1'b0, 1'b1);              // CHECK cycle, tx_done here ignored
    check("f00f_dv",   32'(o_data_valid), 32'h1);
    check("f00f_fe",   32'(o_frame_err), 32'h0);
    check("f00f_data", 32'(o_data), 32'h00F);
    check("f00f_busy_after", 32'(o_busy), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("f00f_dv_one_cycle", 32'(o_data_valid), 32'h0);
    check("f00f_no_extra_fe",  32'(o_frame_err), 32'h0);

    // ---------------- frame 10'h2AA with gaps, done afterwards ----------------
    send_bits(16'h02AA, 10, 1'b1, 1'b0);
    check("f2aa_busy_mid", 32'(o_busy), 32'h1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("f2aa_dv",   32'(o_data_valid), 32'h1);
    check("f2aa_fe",   32'(o_frame_err), 32'h0);
    check("f2aa_data", 32'(o_data), 32'h2AA);

    // ---------------- nine bits -> frame error ----------------
    send_bits(16'h01FF, 9, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("short_fe",   32'(o_frame_err), 32'h1);
    check("short_dv",   32'(o_data_valid), 32'h0);
    check("short_data", 32'(o_data), 32'h2AA);
    step(1'b0, 1'b0, 1'b0);
    check("short_fe_one_cycle", 32'(o_frame_err), 32'h0);

    // ---------------- twelve bits -> overrun error ----------------
    send_bits(16'h0ABC, 12, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("long_fe",   32'(o_frame_err), 32'h1);
    check("long_dv",   32'(o_data_valid), 32'h0);
    check("long_data", 32'(o_data), 32'h2AA);

    // ---------------- eleven bits -> overrun error (boundary) ----------------
    send_bits(16'h0555, 11, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("ovr11_fe",   32'(o_frame_err), 32'h1);
    check("ovr11_data", 32'(o_data), 32'h2AA);

    // ---------------- back-to-back 3FF then 001 ----------------
    send_bits(16'h03FF, 10, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);              // CHECK cycle carries bit 9 of 10'h001
    check("b2b_first_dv",   32'(o_data_valid), 32'h1);
    check("b2b_first_data", 32'(o_data), 32'h3FF);
    check("b2b_busy",       32'(o_busy), 32'h1);
    send_bits(16'h0001, 9, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("b2b_second_dv",   32'(o_data_valid), 32'h1);
    check("b2b_second_fe",   32'(o_frame_err), 32'h0);
    check("b2b_second_data", 32'(o_data), 32'h001);
    step(1'b0, 1'b0, 1'b0);
    check("b2b_hold_data", 32'(o_data), 32'h001);

    // ---------------- reset mid-frame, then 10'h155 ----------------
    send_bits(16'h001F, 5, 1'b0, 1'b0);
    dv_base = dv_cnt; fe_base = fe_cnt;
    i_rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    i_rst = 1'b0;
    check("mrst_busy", 32'(o_busy), 32'h0);
    check("mrst_data", 32'(o_data), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("mrst_no_dv", 32'(dv_cnt - dv_base), 32'h0);
    check("mrst_no_fe", 32'(fe_cnt - fe_base), 32'h0);
    send_bits(16'h0155, 10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("f155_dv",   32'(o_data_valid), 32'h1);
    check("f155_data", 32'(o_data), 32'h155);

    step(1'b0, 1'b0, 1'b0);
    check("never_both", 32'(both_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_receiver
